// File: rtl/arrow_shot_controller_if.sv
// Signal bundle between game logic and the arrow shot sequencer.
// Game logic drives the frame tick and fire button; the sequencer returns
// sprite parameters and the shot-complete pulse.
interface arrow_shot_controller_if;
    logic       frame_start;
    logic       fire_btn;
    logic       arrow_visible;
    logic [9:0] offset_y;
    logic [7:0] arrow_depth;
    logic [1:0] arrow_scale;
    logic [5:0] shot_power;
    logic       shot_done;
    logic [1:0] state;

    modport master (
        output frame_start,
        output fire_btn,
        input  arrow_visible,
        input  offset_y,
        input  arrow_depth,
        input  arrow_scale,
        input  shot_power,
        input  shot_done,
        input  state
    );

    modport slave (
        input  frame_start,
        input  fire_btn,
        output arrow_visible,
        output offset_y,
        output arrow_depth,
        output arrow_scale,
        output shot_power,
        output shot_done,
        output state
    );
endinterface

// File: rtl/arrow_shot_controller.sv
// Frame-synchronous arrow shot sequencer: idle, bow charge, flight, cooldown.
// Every register only moves on a frame_start tick, so the renderer never sees
// sprite parameters change in the middle of a scan.
module arrow_shot_controller #(
    parameter int CHARGE_MAX      = 60,
    parameter int MIN_CHARGE      = 4,
    parameter int FLIGHT_FRAMES   = 32,
    parameter int COOLDOWN_FRAMES = 15
) (
    input  logic                    vga_clk,
    input  logic                    reset_n,
    arrow_shot_controller_if.slave  bus
);

    localparam int FLIGHT_W = $clog2(FLIGHT_FRAMES + 1);
    localparam int COOL_W   = $clog2(COOLDOWN_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CHARGE   = 2'd1,
        ST_FLIGHT   = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_e;

    state_e              state_q,  state_d;
    logic [5:0]          charge_q, charge_d;
    logic [9:0]          offset_q, offset_d;
    logic [7:0]          depth_q,  depth_d;
    logic [FLIGHT_W-1:0] flight_q, flight_d;
    logic [COOL_W-1:0]   cool_q,   cool_d;
    logic [5:0]          power_q,  power_d;
    logic                done_q,   done_d;

    logic [5:0]          chargeInc;
    logic [4:0]          step;
    logic [8:0]          depthSum;
    logic [7:0]          depthNext;
    logic [FLIGHT_W-1:0] flightNext;

    // Saturating charge increment and the flight step derived from latched power.
    assign chargeInc  = (charge_q == 6'(CHARGE_MAX)) ? charge_q : charge_q + 6'd1;
    assign step       = {1'b0, power_q[5:2]} + 5'd1;
    assign depthSum   = {1'b0, depth_q} + {4'b0000, step};
    assign depthNext  = depthSum[8] ? 8'hFF : depthSum[7:0];
    assign flightNext = flight_q + FLIGHT_W'(1);

    // Next-state and register updates, applied only on a frame tick.
    always_comb begin
        state_d  = state_q;
        charge_d = charge_q;
        offset_d = offset_q;
        depth_d  = depth_q;
        flight_d = flight_q;
        cool_d   = cool_q;
        power_d  = power_q;
        done_d   = 1'b0;

        if (bus.frame_start) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.fire_btn) begin
                        state_d  = ST_CHARGE;
                        charge_d = 6'd1;
                        offset_d = 10'd1;
                    end
                end
                ST_CHARGE: begin
                    if (bus.fire_btn) begin
                        charge_d = chargeInc;
                        offset_d = {4'b0000, chargeInc};
                    end else if (charge_q < 6'(MIN_CHARGE)) begin
                        state_d  = ST_IDLE;
                        charge_d = 6'd0;
                        offset_d = 10'd0;
                    end else begin
                        state_d  = ST_FLIGHT;
                        power_d  = charge_q;
                        charge_d = 6'd0;
                        offset_d = 10'd0;
                        depth_d  = 8'd0;
                        flight_d = '0;
                    end
                end
                ST_FLIGHT: begin
                    depth_d  = depthNext;
                    flight_d = flightNext;
                    if ((depthNext == 8'hFF) || (flightNext == FLIGHT_W'(FLIGHT_FRAMES))) begin
                        state_d = ST_COOLDOWN;
                        done_d  = 1'b1;
                        cool_d  = '0;
                    end
                end
                ST_COOLDOWN: begin
                    if (cool_q == COOL_W'(COOLDOWN_FRAMES - 1)) begin
                        state_d  = ST_IDLE;
                        depth_d  = 8'd0;
                        flight_d = '0;
                        cool_d   = '0;
                    end else begin
                        cool_d = cool_q + COOL_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers; reset aborts any shot in progress.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            charge_q <= 6'd0;
            offset_q <= 10'd0;
            depth_q  <= 8'd0;
            flight_q <= '0;
            cool_q   <= '0;
            power_q  <= 6'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            charge_q <= charge_d;
            offset_q <= offset_d;
            depth_q  <= depth_d;
            flight_q <= flight_d;
            cool_q   <= cool_d;
            power_q  <= power_d;
            done_q   <= done_d;
        end
    end

    // Sprite parameters follow registered state so they only move after a tick.
    assign bus.state         = state_q;
    assign bus.arrow_visible = (state_q != ST_COOLDOWN);
    assign bus.offset_y      = offset_q;
    assign bus.arrow_depth   = depth_q;
    assign bus.arrow_scale   = 2'd3 - depth_q[7:6];
    assign bus.shot_power    = power_q;
    assign bus.shot_done     = done_q;

endmodule

// File: tb/tb_arrow_shot_controller.sv
// Directed bench for the arrow shot sequencer with hand-computed expectations.
module tb_arrow_shot_controller;

    logic vga_clk;
    logic reset_n;
    int   total;
    int   bad;
    int   expDepth;

    arrow_shot_controller_if bus ();

    arrow_shot_controller dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running pixel clock.
    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    // One frame tick with the given fire level; outputs sampled 1 unit after the edge.
    task automatic applyStimulus(input logic fire);
        @(negedge vga_clk);
        bus.frame_start = 1'b1;
        bus.fire_btn    = fire;
        @(posedge vga_clk);
        #1;
        bus.frame_start = 1'b0;
    endtask

    // Clock cycles without a tick while the fire button toggles every cycle.
    task automatic toggleWithoutTick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge vga_clk);
            bus.fire_btn = ~bus.fire_btn;
        end
        @(posedge vga_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int st, input int vis, input int off,
                            input int dep, input int scl, input int pwr, input int done);
        checkOutput({tag, ".state"},   32'(bus.state),         32'(st));
        checkOutput({tag, ".visible"}, 32'(bus.arrow_visible), 32'(vis));
        checkOutput({tag, ".offset"},  32'(bus.offset_y),      32'(off));
        checkOutput({tag, ".depth"},   32'(bus.arrow_depth),   32'(dep));
        checkOutput({tag, ".scale"},   32'(bus.arrow_scale),   32'(scl));
        checkOutput({tag, ".power"},   32'(bus.shot_power),    32'(pwr));
        checkOutput({tag, ".done"},    32'(bus.shot_done),     32'(done));
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        reset_n         = 1'b0;
        bus.frame_start = 1'b0;
        bus.fire_btn    = 1'b0;

        // Reset values.
        repeat (3) @(posedge vga_clk);
        #1;
        checkAll("reset", 0, 1, 0, 0, 3, 0, 0);
        @(negedge vga_clk);
        reset_n = 1'b1;
        $display("[TB] reset released");

        // Short press: charge 1,2,3 then release cancels.
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1);
            checkOutput("cancel.state", 32'(bus.state), 32'd1);
            checkOutput("cancel.offset", 32'(bus.offset_y), 32'(k));
        end
        applyStimulus(1'b0);
        checkAll("cancel.release", 0, 1, 0, 0, 3, 0, 0);

        // Long hold: charge saturates at 60, step 16, depth saturates on flight tick 16.
        for (int k = 1; k <= 70; k++) begin
            applyStimulus(1'b1);
            checkOutput("sat.offset", 32'(bus.offset_y), 32'((k > 60) ? 60 : k));
        end
        applyStimulus(1'b0);
        checkAll("sat.release", 2, 1, 0, 0, 3, 60, 0);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b0);
            expDepth = (16 * k > 255) ? 255 : 16 * k;
            checkAll("sat.flight", (k == 16) ? 3 : 2, (k == 16) ? 0 : 1, 0, expDepth,
                     3 - (expDepth >> 6), 60, (k == 16) ? 1 : 0);
        end
        @(posedge vga_clk);
        #1;
        checkOutput("sat.donePulse", 32'(bus.shot_done), 32'd0);
        for (int k = 1; k <= 15; k++) begin
            applyStimulus(1'b0);
            checkOutput("sat.cool.state", 32'(bus.state), 32'((k == 15) ? 0 : 3));
        end
        checkAll("sat.idle", 0, 1, 0, 0, 3, 60, 0);

        // Twenty-tick press with button toggling between ticks mid-charge.
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b1);
            checkOutput("mid.offset", 32'(bus.offset_y), 32'(k));
            if (k == 5) begin
                toggleWithoutTick(7);
                checkOutput("notick.state", 32'(bus.state), 32'd1);
                checkOutput("notick.offset", 32'(bus.offset_y), 32'd5);
            end
        end
        applyStimulus(1'b0);
        checkAll("mid.release", 2, 1, 0, 0, 3, 20, 0);
        for (int k = 1; k <= 32; k++) begin
            applyStimulus(1'b0);
            checkAll("mid.flight", (k == 32) ? 3 : 2, (k == 32) ? 0 : 1, 0, 6 * k,
                     3 - ((6 * k) >> 6), 20, (k == 32) ? 1 : 0);
        end

        // Cooldown with fire held: hidden for 15 ticks, then re-arm on next tick.
        for (int k = 1; k <= 15; k++) begin
            applyStimulus(1'b1);
            if (k < 15)
                checkAll("cool.held", 3, 0, 0, 192, 0, 20, 0);
            else
                checkAll("cool.exit", 0, 1, 0, 0, 3, 20, 0);
        end
        applyStimulus(1'b1);
        checkAll("rearm", 1, 1, 1, 0, 3, 20, 0);
        applyStimulus(1'b0);
        checkAll("rearm.cancel", 0, 1, 0, 0, 3, 20, 0);

        // Reset during flight at depth 48 aborts the shot.
        for (int k = 1; k <= 20; k++) applyStimulus(1'b1);
        applyStimulus(1'b0);
        for (int k = 1; k <= 8; k++) applyStimulus(1'b0);
        checkAll("preReset", 2, 1, 0, 48, 3, 20, 0);
        @(negedge vga_clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkAll("midReset", 0, 1, 0, 0, 3, 0, 0);
        @(negedge vga_clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0);
            checkOutput("postReset.done", 32'(bus.shot_done), 32'd0);
            checkOutput("postReset.state", 32'(bus.state), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
